speed_switch_controller: RTL and testbench

- Implements the CGB KEY1 register (FF4D) and the double-speed switch sequence triggered by STOP.
- Sits directly downstream of the KEY0/CGB mode register and consumes its cgb_soft output to gate all behaviour.
- Drives double_speed to the clock-enable generator, and drives cpu_stall and div_reset to the CPU and timer while a switch is in progress.

---
 rtl/speed_switch_controller_pkg.sv | 24 ++
 rtl/speed_switch_controller.sv | 98 +++++++++
 tb/tb_speed_switch_controller.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/speed_switch_controller_pkg.sv
// Purpose: shared console definitions for the CGB KEY1 (speed switch) register.
// Contents: register address, KEY1 bit positions, switch FSM state encoding,
//           and a helper that packs the KEY1 read value.
package speed_switch_controller_pkg;

  localparam logic [15:0] KEY1_ADDR        = 16'hFF4D;
  localparam int          KEY1_PREPARE_BIT = 0;
  localparam int          KEY1_SPEED_BIT   = 7;

  typedef enum logic [0:0] {
    SS_IDLE      = 1'b0,
    SS_SWITCHING = 1'b1
  } speed_sw_state_t;

  // KEY1 read layout: bit7 = current speed, bit0 = prepare, bits 6..1 read as 1.
  function automatic logic [7:0] key1_pack(input logic speed, input logic prepare);
    logic [7:0] v;
    v                   = 8'hFF;
    v[KEY1_SPEED_BIT]   = speed;
    v[KEY1_PREPARE_BIT] = prepare;
    return v;
  endfunction

endpackage

// File: rtl/speed_switch_controller.sv
// Purpose: KEY1 register and the STOP-triggered CGB double-speed switch sequence.
// Ports:   clk/reset (sync, active-high), cpu_en tick enable, cgb_soft gate,
//          KEY1 read/write (rdata, wdata, write), stop_req; outputs double_speed,
//          cpu_stall, div_reset and switch_done pulses.
module speed_switch_controller
  import speed_switch_controller_pkg::*;
#(
  parameter int SWITCH_CYCLES = 2050,
  parameter int CNT_W         = $clog2(SWITCH_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       cgb_soft,
  output logic [7:0] rdata,
  input  logic [7:0] wdata,
  input  logic       write,
  input  logic       stop_req,
  output logic       double_speed,
  output logic       cpu_stall,
  output logic       div_reset,
  output logic       switch_done
);

  // SWITCH_CYCLES=1 gives a zero-width counter; keep at least one bit.
  localparam int            CW       = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SWITCH_CYCLES - 1);

  speed_sw_state_t r_state;
  logic [CW-1:0]   r_count;
  logic            r_prepare;
  logic            r_double_speed;
  logic            r_div_reset;
  logic            r_switch_done;

  logic            w_accept;
  logic            w_unused_wdata;

  // Only the prepare bit of a KEY1 write is meaningful.
  assign w_unused_wdata = ^wdata[7:1];

  // Decision uses the registered prepare, so a same-tick write cannot influence it.
  assign w_accept = cpu_en & cgb_soft & stop_req & r_prepare & (r_state == SS_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= SS_IDLE;
      r_count        <= '0;
      r_prepare      <= 1'b0;
      r_double_speed <= 1'b0;
      r_div_reset    <= 1'b0;
      r_switch_done  <= 1'b0;
    end else begin
      // Pulses last exactly one clk regardless of cpu_en.
      r_div_reset   <= 1'b0;
      r_switch_done <= 1'b0;
      if (cpu_en) begin
        if (!cgb_soft) begin
          // Leaving CGB mode aborts any switch and forces normal speed.
          r_state        <= SS_IDLE;
          r_prepare      <= 1'b0;
          r_double_speed <= 1'b0;
        end else begin
          case (r_state)
            SS_IDLE: begin
              if (w_accept) begin
                // Accepted switch swallows a write issued in the same tick.
                r_state     <= SS_SWITCHING;
                r_count     <= CNT_LOAD;
                r_div_reset <= 1'b1;
              end else if (write) begin
                r_prepare <= wdata[KEY1_PREPARE_BIT];
              end
            end
            SS_SWITCHING: begin
              if (r_count == '0) begin
                r_state        <= SS_IDLE;
                r_prepare      <= 1'b0;
                r_double_speed <= ~r_double_speed;
                r_switch_done  <= 1'b1;
              end else begin
                r_count <= r_count - 1'b1;
              end
            end
            default: r_state <= SS_IDLE;
          endcase
        end
      end
    end
  end

  assign rdata        = cgb_soft ? key1_pack(r_double_speed, r_prepare) : 8'hFF;
  assign double_speed = r_double_speed;
  assign cpu_stall    = (r_state == SS_SWITCHING);
  assign div_reset    = r_div_reset;
  assign switch_done  = r_switch_done;

endmodule

// File: tb/tb_speed_switch_controller.sv
module tb_speed_switch_controller;

  localparam int SWC = 4;

  logic       clk = 1'b0;
  logic       reset, cpu_en, cgb_soft, write, stop_req;
  logic [7:0] wdata, rdata;
  logic       double_speed, cpu_stall, div_reset, switch_done;

  speed_switch_controller #(.SWITCH_CYCLES(SWC)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .cgb_soft(cgb_soft),
    .rdata(rdata), .wdata(wdata), .write(write), .stop_req(stop_req),
    .double_speed(double_speed), .cpu_stall(cpu_stall),
    .div_reset(div_reset), .switch_done(switch_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rd;
    logic       ds;
    logic       st;
    logic       dr;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Observed pulse/stall statistics for scenario-level checks.
  int stall_ticks = 0;
  int divr_cnt    = 0;
  int done_cnt    = 0;

  // Reference model state.
  logic       m_prep, m_ds, m_sw, m_divr, m_done;
  int         m_cnt;

  // Values the next cyc() applies to reset and cgb_soft.
  logic g_rst = 1'b1;
  logic g_cgb = 1'b1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model across one clk edge using the inputs present at that edge.
  task automatic model_edge();
    if (reset) begin
      m_prep = 1'b0; m_ds = 1'b0; m_sw = 1'b0; m_cnt = 0; m_divr = 1'b0; m_done = 1'b0;
    end else begin
      m_divr = 1'b0;
      m_done = 1'b0;
      if (cpu_en) begin
        if (!cgb_soft) begin
          m_sw = 1'b0; m_prep = 1'b0; m_ds = 1'b0;
        end else if (!m_sw) begin
          if (stop_req && m_prep) begin
            m_sw = 1'b1; m_cnt = SWC - 1; m_divr = 1'b1;
          end else if (write) begin
            m_prep = wdata[0];
          end
        end else if (m_cnt > 0) begin
          m_cnt = m_cnt - 1;
        end else begin
          m_ds = ~m_ds; m_prep = 1'b0; m_sw = 1'b0; m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input logic en, input logic wr, input logic [7:0] wd, input logic stp);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    reset = g_rst; cgb_soft = g_cgb;
    cpu_en = en; write = wr; wdata = wd; stop_req = stp;
    e.rd = cgb_soft ? {m_ds, 6'b111111, m_prep} : 8'hFF;
    e.ds = m_ds;
    e.st = m_sw;
    e.dr = m_divr;
    e.dn = m_done;
    exp_q.push_back(e);
  endtask

  // One cpu_en tick carrying the given request, followed by an idle clk.
  task automatic tick(input logic wr, input logic [7:0] wd, input logic stp);
    cyc(1'b1, wr, wd, stp);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_stats();
    stall_ticks = 0; divr_cnt = 0; done_cnt = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_eq("rdata",        32'(rdata),        32'(e.rd));
      chk_eq("double_speed", 32'(double_speed), 32'(e.ds));
      chk_eq("cpu_stall",    32'(cpu_stall),    32'(e.st));
      chk_eq("div_reset",    32'(div_reset),    32'(e.dr));
      chk_eq("switch_done",  32'(switch_done),  32'(e.dn));
      if (cpu_en && cpu_stall) stall_ticks++;
      if (div_reset)   divr_cnt++;
      if (switch_done) done_cnt++;
    end
  end

  initial begin
    reset = 1'b1; cgb_soft = 1'b1; cpu_en = 1'b0; write = 1'b0; wdata = 8'h00; stop_req = 1'b0;
    m_prep = 1'b0; m_ds = 1'b0; m_sw = 1'b0; m_cnt = 0; m_divr = 1'b0; m_done = 1'b0;

    // 1: reset state and prepare writes
    g_rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    g_rst = 1'b0;
    tick(1'b0, 8'h00, 1'b0);
    chk_eq("t1_reset_rd", 32'(rdata), 32'h7E);
    tick(1'b1, 8'h01, 1'b0);
    chk_eq("t1_prep_set", 32'(rdata), 32'h7F);
    tick(1'b1, 8'hFE, 1'b0);
    chk_eq("t1_prep_clr", 32'(rdata), 32'h7E);

    // 2: full switch to double speed and back
    tick(1'b1, 8'h01, 1'b0);
    clear_stats();
    tick(1'b0, 8'h00, 1'b1);
    repeat (5) tick(1'b0, 8'h00, 1'b0);
    chk_eq("t2_stall_ticks", 32'(stall_ticks), 32'd4);
    chk_eq("t2_div_pulses",  32'(divr_cnt),    32'd1);
    chk_eq("t2_done_pulses", 32'(done_cnt),    32'd1);
    chk_eq("t2_ds_on",       32'(double_speed), 32'd1);
    chk_eq("t2_rd_fast",     32'(rdata),       32'hFE);
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    repeat (5) tick(1'b0, 8'h00, 1'b0);
    chk_eq("t2_ds_off",      32'(double_speed), 32'd0);
    chk_eq("t2_rd_slow",     32'(rdata),       32'h7E);

    // 3: DMG mode ignores KEY1 and STOP
    g_cgb = 1'b0;
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h01, 1'b0);
    chk_eq("t3_rd_dmg", 32'(rdata), 32'hFF);
    clear_stats();
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    chk_eq("t3_no_stall", 32'(stall_ticks), 32'd0);
    chk_eq("t3_no_div",   32'(divr_cnt),    32'd0);
    g_cgb = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    chk_eq("t3_prep_kept0", 32'(rdata), 32'h7E);

    // 4a: reach double speed, then drop cgb_soft mid-switch
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    repeat (5) tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h01, 1'b0);
    clear_stats();
    tick(1'b0, 8'h00, 1'b1);
    repeat (2) tick(1'b0, 8'h00, 1'b0);
    g_cgb = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_eq("t4_abort_stall", 32'(cpu_stall),    32'd0);
    chk_eq("t4_abort_ds",    32'(double_speed), 32'd0);
    g_cgb = 1'b1;
    repeat (4) tick(1'b0, 8'h00, 1'b0);
    chk_eq("t4_abort_nodone", 32'(done_cnt), 32'd0);

    // 4b: reset while switching
    tick(1'b1, 8'h01, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    repeat (5) tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h01, 1'b0);
    clear_stats();
    tick(1'b0, 8'h00, 1'b1);
    repeat (2) tick(1'b0, 8'h00, 1'b0);
    g_rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    g_rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk_eq("t4_rst_ds",    32'(double_speed), 32'd0);
    chk_eq("t4_rst_stall", 32'(cpu_stall),    32'd0);
    chk_eq("t4_rst_rd",    32'(rdata),        32'h7E);
    repeat (4) tick(1'b0, 8'h00, 1'b0);
    chk_eq("t4_rst_nodone", 32'(done_cnt), 32'd0);

    // 5: same-tick write and STOP; writes during switch dropped
    tick(1'b1, 8'h01, 1'b0);
    clear_stats();
    tick(1'b1, 8'h00, 1'b1);
    chk_eq("t5_accepted", 32'(cpu_stall), 32'd1);
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    chk_eq("t5_prep_held", 32'(rdata), 32'h7F);
    repeat (4) tick(1'b0, 8'h00, 1'b0);
    chk_eq("t5_done",  32'(done_cnt),     32'd1);
    chk_eq("t5_ds",    32'(double_speed), 32'd1);
    chk_eq("t5_rd",    32'(rdata),        32'hFE);

    // 6: STOP without prepare, plus requests on non-enable clks
    clear_stats();
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b0);
    chk_eq("t6_no_stall", 32'(stall_ticks), 32'd0);
    chk_eq("t6_no_div",   32'(divr_cnt),    32'd0);
    chk_eq("t6_frozen",   32'(rdata),       32'hFE);

    @(negedge clk);
    #1;
    chk_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
